// File: rtl/clk_div_monitor.sv
// Same-domain monitor for a divided clock: measures each div_clk phase at
// half-cycle resolution of in_clk, locks after consecutive good phases.
module clk_div_monitor #(
  parameter int EXP_HIGH = 5,
  parameter int EXP_LOW  = 5,
  parameter int LOCK_CNT = 4,
  parameter int CW       = 8
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          div_clk,
  input  logic          en,
  input  logic          err_clr,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] hi_len,
  output logic [CW-1:0] lo_len,
  output logic [15:0]   rise_cnt,
  output logic [1:0]    state_dbg
);

  localparam int            GW       = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LEN_MAX  = '1;
  localparam logic [CW-1:0] EXP_HI_V = CW'(EXP_HIGH);
  localparam logic [CW-1:0] EXP_LO_V = CW'(EXP_LOW);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_ACQ  = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  // Tracking context threaded through the two half-cycle samples of a cycle.
  typedef struct packed {
    state_t        st;
    logic          lvl;
    logic [CW-1:0] len;
    logic [GW-1:0] good;
    logic [CW-1:0] hl;
    logic [CW-1:0] ll;
    logic [15:0]   rc;
    logic          err_set;
  } trk_t;

  state_t        st_q, st_d;
  logic          neg_s_q, neg_s_d;
  logic          run_lvl_q, run_lvl_d;
  logic [CW-1:0] run_len_q, run_len_d;
  logic [GW-1:0] good_q, good_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [CW-1:0] hi_len_q, hi_len_d;
  logic [CW-1:0] lo_len_q, lo_len_d;
  logic [15:0]   rise_cnt_q, rise_cnt_d;
  trk_t          t0, t1, t2;

  function automatic trk_t step(input trk_t t_in, input logic s);
    trk_t t;
    logic eval;
    logic ok;
    logic stuck;
    t     = t_in;
    eval  = 1'b0;
    ok    = 1'b0;
    stuck = 1'b0;
    if (s == t.lvl) begin
      if (t.len != LEN_MAX) t.len = t.len + 1'b1;
      stuck = (t.len == LEN_MAX);
      eval  = stuck && (t.st != S_SYNC);
    end else begin
      if (s) t.rc = t.rc + 16'd1;
      if (t.st == S_SYNC) begin
        // The first phase after enabling is partial and never judged.
        t.st   = S_ACQ;
        t.good = '0;
      end else begin
        eval = 1'b1;
        if (t.lvl) begin
          ok   = (t.len == EXP_HI_V);
          t.hl = t.len;
        end else begin
          ok   = (t.len == EXP_LO_V);
          t.ll = t.len;
        end
      end
      t.lvl = s;
      t.len = CW'(1);
    end
    if (eval) begin
      case (t.st)
        S_ACQ: begin
          if (ok) begin
            t.good = t.good + 1'b1;
            if (t.good == LOCK_V) t.st = S_LOCK;
          end else begin
            t.good = '0;
          end
        end
        S_LOCK: begin
          if (!ok) begin
            t.err_set = 1'b1;
            t.st      = S_ACQ;
            t.good    = '0;
            if (stuck) t.len = '0;
          end
        end
        default: ;
      endcase
    end
    return t;
  endfunction

  always_comb begin
    neg_s_d = div_clk;
  end

  always_comb begin
    t0.st      = st_q;
    t0.lvl     = run_lvl_q;
    t0.len     = run_len_q;
    t0.good    = good_q;
    t0.hl      = hi_len_q;
    t0.ll      = lo_len_q;
    t0.rc      = rise_cnt_q;
    t0.err_set = 1'b0;
    t1 = step(t0, neg_s_q);
    t2 = step(t1, div_clk);

    st_d       = t2.st;
    run_lvl_d  = t2.lvl;
    run_len_d  = t2.len;
    good_d     = t2.good;
    hi_len_d   = t2.hl;
    lo_len_d   = t2.ll;
    rise_cnt_d = t2.rc;
    err_d      = t2.err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    // Disabled or idle: follow the level only, keep lengths and err.
    if (!en || st_q == S_IDLE) begin
      st_d       = en ? S_SYNC : S_IDLE;
      run_lvl_d  = div_clk;
      run_len_d  = '0;
      good_d     = '0;
      hi_len_d   = hi_len_q;
      lo_len_d   = lo_len_q;
      rise_cnt_d = '0;
      err_d      = err_clr ? 1'b0 : err_q;
    end

    locked_d = (st_d == S_LOCK);
  end

  always_ff @(negedge in_clk or negedge in_rst) begin
    if (!in_rst) neg_s_q <= 1'b0;
    else         neg_s_q <= neg_s_d;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      st_q       <= S_IDLE;
      run_lvl_q  <= 1'b0;
      run_len_q  <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      hi_len_q   <= '0;
      lo_len_q   <= '0;
      rise_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      run_lvl_q  <= run_lvl_d;
      run_len_q  <= run_len_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      hi_len_q   <= hi_len_d;
      lo_len_q   <= lo_len_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign hi_len    = hi_len_q;
  assign lo_len    = lo_len_q;
  assign rise_cnt  = rise_cnt_q;
  assign state_dbg = st_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: table of phase-pattern vectors checked through an
// expected queue, plus hand sequences for lock loss, stuck, clear, reset, wrap.
module tb_clk_div_monitor;

  localparam int CW = 8;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b1;
  logic          div_clk = 1'b0;
  logic          en = 1'b0;
  logic          err_clr = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] hi_len;
  logic [CW-1:0] lo_len;
  logic [15:0]   rise_cnt;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        l;
    logic        e;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] rc;
  } obs_t;

  typedef struct {
    int   n1;
    int   h2;
    int   l2;
    int   n2;
    logic e_locked;
    logic e_err;
    int   e_hi;
    int   e_lo;
    int   e_rise;
  } vec_t;

  vec_t       vecs[8];
  logic [33:0] exp_q[$];

  clk_div_monitor #(
    .EXP_HIGH(5),
    .EXP_LOW (5),
    .LOCK_CNT(4),
    .CW      (CW)
  ) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .div_clk  (div_clk),
    .en       (en),
    .err_clr  (err_clr),
    .locked   (locked),
    .err      (err),
    .hi_len   (hi_len),
    .lo_len   (lo_len),
    .rise_cnt (rise_cnt),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 in_clk = ~in_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    en      = 1'b0;
    err_clr = 1'b0;
    div_clk = 1'b0;
    in_rst  = 1'b1;
    #1 in_rst = 1'b0;
    @(posedge in_clk);
    @(posedge in_clk);
    #2 in_rst = 1'b1;
  endtask

  // Driver: one div_clk half-cycle per in_clk edge
  task automatic put_half(input logic v);
    @(in_clk);
    #1 div_clk = v;
  endtask

  task automatic phase(input logic v, input int n);
    repeat (n) put_half(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp_v);
    n_checks++;
    if (act !== 32'(exp_v)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Scoreboard compare against the oldest expected record
  task automatic check_obs(input int idx);
    obs_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL v%0d scoreboard: got empty queue expected one record", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d locked", idx), 32'(locked), int'(e.l));
      chk($sformatf("v%0d err", idx), 32'(err), int'(e.e));
      chk($sformatf("v%0d hi_len", idx), 32'(hi_len), int'(e.hi));
      chk($sformatf("v%0d lo_len", idx), 32'(lo_len), int'(e.lo));
      chk($sformatf("v%0d rise_cnt", idx), 32'(rise_cnt), int'(e.rc));
    end
  endtask

  task automatic run_vec(input int i);
    obs_t o;
    do_reset();
    en   = 1'b1;
    o.l  = vecs[i].e_locked;
    o.e  = vecs[i].e_err;
    o.hi = 8'(vecs[i].e_hi);
    o.lo = 8'(vecs[i].e_lo);
    o.rc = 16'(vecs[i].e_rise);
    exp_q.push_back(o);
    phase(1'b0, 4);
    repeat (vecs[i].n1) begin
      phase(1'b1, 5);
      phase(1'b0, 5);
    end
    repeat (vecs[i].n2) begin
      phase(1'b1, vecs[i].h2);
      phase(1'b0, vecs[i].l2);
    end
    phase(1'b1, 5);
    check_obs(i);
  endtask

  initial begin
    //            n1 h2 l2 n2 lock  err   hi lo rise
    vecs[0] = '{2, 5, 5, 0, 1'b1, 1'b0, 5, 5, 3};
    vecs[1] = '{1, 5, 5, 0, 1'b0, 1'b0, 5, 5, 2};
    vecs[2] = '{0, 4, 5, 3, 1'b0, 1'b0, 4, 5, 4};
    vecs[3] = '{2, 4, 5, 1, 1'b0, 1'b1, 4, 5, 4};
    vecs[4] = '{2, 5, 6, 1, 1'b0, 1'b1, 5, 6, 4};
    vecs[5] = '{3, 6, 4, 2, 1'b0, 1'b1, 6, 4, 6};
    vecs[6] = '{2, 1, 9, 1, 1'b0, 1'b1, 1, 9, 4};
    vecs[7] = '{1, 6, 4, 2, 1'b0, 1'b0, 6, 4, 4};

    do_reset();
    #1;
    chk("reset locked", 32'(locked), 0);
    chk("reset err", 32'(err), 0);
    chk("reset hi_len", 32'(hi_len), 0);
    chk("reset lo_len", 32'(lo_len), 0);
    chk("reset rise_cnt", 32'(rise_cnt), 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Clean lock, then steady rise counting
    do_reset();
    en = 1'b1;
    phase(1'b0, 4);
    repeat (2) begin
      phase(1'b1, 5);
      phase(1'b0, 5);
    end
    chk("no early lock", 32'(locked), 0);
    phase(1'b1, 5);
    chk("lock locked", 32'(locked), 1);
    chk("lock err", 32'(err), 0);
    chk("lock hi_len", 32'(hi_len), 5);
    chk("lock lo_len", 32'(lo_len), 5);
    chk("lock rise_cnt", 32'(rise_cnt), 3);
    for (int k = 1; k <= 4; k++) begin
      phase(1'b0, 5);
      phase(1'b1, 5);
      chk($sformatf("steady rise %0d", k), 32'(rise_cnt), 3 + k);
      chk($sformatf("steady locked %0d", k), 32'(locked), 1);
    end

    // Short high phase after lock, relock with err held, then clear
    phase(1'b0, 5);
    phase(1'b1, 4);
    phase(1'b0, 5);
    chk("glitch err", 32'(err), 1);
    chk("glitch locked", 32'(locked), 0);
    chk("glitch hi_len", 32'(hi_len), 4);
    phase(1'b1, 5);
    phase(1'b0, 5);
    chk("relock early", 32'(locked), 0);
    phase(1'b1, 5);
    phase(1'b0, 5);
    chk("relock locked", 32'(locked), 1);
    chk("relock err held", 32'(err), 1);
    err_clr = 1'b1;
    phase(1'b1, 2);
    err_clr = 1'b0;
    phase(1'b1, 3);
    chk("clr err", 32'(err), 0);
    chk("clr locked", 32'(locked), 1);

    // Stuck low
    phase(1'b0, 254);
    chk("prestuck locked", 32'(locked), 1);
    chk("prestuck err", 32'(err), 0);
    phase(1'b0, 4);
    chk("stuck err", 32'(err), 1);
    chk("stuck locked", 32'(locked), 0);
    chk("stuck lo_len", 32'(lo_len), 5);

    // Relock, then a bad phase landing on the same edge as err_clr
    phase(1'b1, 5);
    phase(1'b0, 5);
    phase(1'b1, 5);
    phase(1'b0, 5);
    phase(1'b1, 5);
    chk("coll pre locked", 32'(locked), 1);
    chk("coll pre err", 32'(err), 1);
    phase(1'b1, 1);
    @(negedge in_clk);
    #1;
    div_clk = 1'b0;
    err_clr = 1'b1;
    @(posedge in_clk);
    #1 err_clr = 1'b0;
    chk("coll err", 32'(err), 1);
    chk("coll locked", 32'(locked), 0);

    // Disable while locked
    do_reset();
    en = 1'b1;
    phase(1'b0, 4);
    repeat (2) begin
      phase(1'b1, 5);
      phase(1'b0, 5);
    end
    phase(1'b1, 5);
    chk("dis pre locked", 32'(locked), 1);
    en = 1'b0;
    @(posedge in_clk);
    #1;
    chk("dis locked", 32'(locked), 0);
    chk("dis hi_len", 32'(hi_len), 5);
    chk("dis lo_len", 32'(lo_len), 5);
    chk("dis err", 32'(err), 0);

    // Asynchronous reset during acquisition
    do_reset();
    en = 1'b1;
    phase(1'b0, 4);
    phase(1'b1, 5);
    phase(1'b0, 5);
    phase(1'b1, 3);
    chk("rst pre hi_len", 32'(hi_len), 5);
    chk("rst pre rise_cnt", 32'(rise_cnt), 2);
    in_rst = 1'b0;
    #1;
    chk("rst locked", 32'(locked), 0);
    chk("rst err", 32'(err), 0);
    chk("rst hi_len", 32'(hi_len), 0);
    chk("rst lo_len", 32'(lo_len), 0);
    chk("rst rise_cnt", 32'(rise_cnt), 0);
    in_rst = 1'b1;

    // Rise counter wrap with a fast toggling input
    do_reset();
    en = 1'b1;
    phase(1'b0, 4);
    for (int k = 0; k < 65535; k++) begin
      put_half(1'b1);
      put_half(1'b0);
    end
    phase(1'b0, 3);
    chk("wrap ffff", 32'(rise_cnt), 65535);
    chk("wrap pre err", 32'(err), 0);
    phase(1'b1, 4);
    chk("wrap zero", 32'(rise_cnt), 0);
    chk("wrap err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checks a divided clock produced from `in_clk`, such as the 50%-duty divide-by-5 output, in the same clock domain. It measures every high and low phase of `div_clk` at half-cycle resolution of `in_clk`. It compares each phase against the expected lengths and raises `locked` after a run of consecutive good phases. It raises a sticky `err` on any mismatch or stuck clock, and reports the last measured phase lengths.

## Interface
- `EXP_HIGH`, default 5: expected high-phase length, in `in_clk` half-cycles.
- `EXP_LOW`, default 5: expected low-phase length, in `in_clk` half-cycles.
- `LOCK_CNT`, default 4: number of consecutive good completed phases required to assert `locked`.
- `CW`, default 8: width of the phase-length counter and length outputs.
- `in_clk`  in  1  clock.
- `in_rst`  in  1  reset, asynchronous, active-low.
- `div_clk`  in  1  divided clock under test; changes only on `in_clk` edges, so no synchronizer is used.
- `en`  in  1  monitor enable.
- `err_clr`  in  1  clears sticky `err`.
- `locked`  out  1  frequency and duty are confirmed.
- `err`  out  1  sticky error flag.
- `hi_len`  out  CW  length of the last completed high phase, in half-cycles.
- `lo_len`  out  CW  length of the last completed low phase, in half-cycles.
- `rise_cnt`  out  16  number of `div_clk` rising edges seen since leaving IDLE; wraps.

## Operation
- **Sampling.** `neg_s` samples `div_clk` on negedge `in_clk`; this is the level during the first half of the cycle. At each posedge, `div_clk` gives the level during the second half. Each posedge processes the ordered pair (`neg_s`, `div_clk`) as two half-cycle samples, in sequence, within one cycle.
- **Run tracking.** `run_lvl` holds the current level and `run_len` counts half-cycles at that level.
  - On each sample equal to `run_lvl`: `run_len` increments, saturating at 2^CW-1.
  - On each sample different from `run_lvl`, the phase completes. `run_len` is compared with `EXP_HIGH` when `run_lvl` is 1, or `EXP_LOW` when `run_lvl` is 0. The length is stored to `hi_len` or `lo_len`. Then `run_lvl` is set to the new level and `run_len` to 1.
  - A 0→1 change increments `rise_cnt`.
  - Both samples of one pair may complete phases, for example a 1-half-cycle glitch. Both are evaluated in order, and any bad result counts as an error.
- **Stuck clock.** `run_len` reaching 2^CW-1 is a stuck error.
- **State machine.**
  - IDLE: `en`=0. Counters are held at 0, `locked`=0, and `run_lvl` is loaded from each sample. `en`=1 → SYNC.
  - SYNC: waits for the first level change. That first, partial phase is discarded: no compare, no length store, `rise_cnt` still counts. On the change → ACQ with good count 0.
  - ACQ: each good phase increments the good count. Good count reaching `LOCK_CNT` → LOCK and `locked`=1. A bad phase or stuck condition resets the good count and stays in ACQ; `err` is not set.
  - LOCK: a bad phase or stuck condition sets `err`=1, clears `locked`, goes to ACQ with good count 0, and resets `run_len` to 0 on a stuck error.
  - `en`=0 in any state → IDLE next posedge. `locked` clears; `err` and the length outputs hold.
- **Clearing `err`.** `err_clr`=1 clears `err`. If a new error occurs in the same cycle as `err_clr`, the set wins.

## Timing
- All outputs are registered on posedge `in_clk`.
- Reset values: `locked`=0, `err`=0, `hi_len`=0, `lo_len`=0, `rise_cnt`=0, state IDLE, `run_len`=0.
- A `div_clk` transition at either edge of cycle k is processed at posedge k+1 at the latest. Outputs are visible after that posedge, so latency is at most 1.5 `in_clk` cycles.
- `locked` rises at the posedge processing the `LOCK_CNT`-th consecutive good phase.
- Asserting `in_rst` mid-operation returns everything to reset values immediately. Monitoring restarts through IDLE→SYNC.

## Test plan
- **Clean lock.** Divide-by-5 clock (5 high / 5 low half-cycles), `en`=1 → `locked`=1 after the partial phase plus 4 phases (about 10-13 `in_clk` cycles). Then `hi_len`=5, `lo_len`=5, `err`=0, and `rise_cnt` increments once per 5 cycles.
- **Glitch after lock.** A high phase of 4 half-cycles → `err`=1, `locked`=0, `hi_len`=4. Then 4 good phases → `locked`=1 again while `err` stays 1. `err_clr` pulse → `err`=0.
- **Stuck low.** Hold `div_clk`=0 after lock for 255 half-cycles → `err`=1 and `locked`=0. No `lo_len` update occurs until the next edge.
- **Clear/set collision.** `err_clr` in the same cycle as a new bad phase → `err` stays 1.
- **Disable and reset.** `en`=0 while locked → `locked`=0 next cycle, with `hi_len`/`lo_len` held. `in_rst` low mid-ACQ → all outputs 0 asynchronously.
- **Counter wrap.** Preload or run to `rise_cnt`=0xFFFF; the next rising edge → 0x0000, with no error.
